// File: rtl/idex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS datapath.
// Detects load-use hazards against the load in EX, inserting one bubble and holding IF/ID.
module idex_stage #(
    parameter int WORD_W  = 32,
    parameter int REG_W   = 5,
    parameter int ALUOP_W = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               en,
    input  logic               flush,
    input  logic               id_valid,
    input  logic [REG_W-1:0]   id_rs,
    input  logic [REG_W-1:0]   id_rt,
    input  logic [REG_W-1:0]   id_rd,
    input  logic [WORD_W-1:0]  id_rdat1,
    input  logic [WORD_W-1:0]  id_rdat2,
    input  logic [WORD_W-1:0]  id_imm32,
    input  logic [WORD_W-1:0]  id_pc4,
    input  logic [ALUOP_W-1:0] id_aluop,
    input  logic               id_alusrc,
    input  logic               id_regW,
    input  logic               id_memren,
    input  logic               id_memwen,
    input  logic               id_ri_enable,
    output logic               idex_valid,
    output logic [REG_W-1:0]   idex_rs,
    output logic [REG_W-1:0]   idex_rt,
    output logic [REG_W-1:0]   idex_rd,
    output logic [WORD_W-1:0]  idex_rdat1,
    output logic [WORD_W-1:0]  idex_rdat2,
    output logic [WORD_W-1:0]  idex_imm32,
    output logic [WORD_W-1:0]  idex_pc4,
    output logic [ALUOP_W-1:0] idex_aluop,
    output logic               idex_alusrc,
    output logic               idex_regW,
    output logic               idex_memren,
    output logic               idex_memwen,
    output logic               idex_ri_enable,
    output logic               ifid_hold,
    output logic [15:0]        bubble_cnt
);

    typedef struct packed {
        logic               valid;
        logic [REG_W-1:0]   rs;
        logic [REG_W-1:0]   rt;
        logic [REG_W-1:0]   rd;
        logic [WORD_W-1:0]  rdat1;
        logic [WORD_W-1:0]  rdat2;
        logic [WORD_W-1:0]  imm32;
        logic [WORD_W-1:0]  pc4;
        logic [ALUOP_W-1:0] aluop;
        logic               alusrc;
        logic               regW;
        logic               memren;
        logic               memwen;
        logic               ri_enable;
    } idex_t;

    idex_t       idex_q, idex_d, cap;
    logic [15:0] bubble_cnt_q, bubble_cnt_d;
    logic        hz;

    // Bubbles carry regW=0/memren=0, so a bubble in EX can never match here.
    always_comb begin
        hz = idex_q.valid & idex_q.memren & idex_q.regW & (idex_q.rd != '0) & id_valid &
             ((idex_q.rd == id_rs) | ((idex_q.rd == id_rt) & (id_ri_enable | id_memwen)));
        ifid_hold = hz & ~flush & ~RST;
    end

    always_comb begin
        cap.valid     = id_valid;
        cap.rs        = id_rs;
        cap.rt        = id_rt;
        cap.rd        = id_rd;
        cap.rdat1     = id_rdat1;
        cap.rdat2     = id_rdat2;
        cap.imm32     = id_imm32;
        cap.pc4       = id_pc4;
        cap.aluop     = id_aluop & {ALUOP_W{id_valid}};
        cap.alusrc    = id_alusrc & id_valid;
        cap.regW      = id_regW & id_valid;
        cap.memren    = id_memren & id_valid;
        cap.memwen    = id_memwen & id_valid;
        cap.ri_enable = id_ri_enable & id_valid;
    end

    always_comb begin
        idex_d       = idex_q;
        bubble_cnt_d = bubble_cnt_q;
        if (en) begin
            if (flush) begin
                idex_d = '0;
            end else if (hz) begin
                idex_d = '0;
                if (bubble_cnt_q != 16'hFFFF) begin
                    bubble_cnt_d = bubble_cnt_q + 16'd1;
                end
            end else begin
                idex_d = cap;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            idex_q       <= '0;
            bubble_cnt_q <= '0;
        end else begin
            idex_q       <= idex_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign idex_valid     = idex_q.valid;
    assign idex_rs        = idex_q.rs;
    assign idex_rt        = idex_q.rt;
    assign idex_rd        = idex_q.rd;
    assign idex_rdat1     = idex_q.rdat1;
    assign idex_rdat2     = idex_q.rdat2;
    assign idex_imm32     = idex_q.imm32;
    assign idex_pc4       = idex_q.pc4;
    assign idex_aluop     = idex_q.aluop;
    assign idex_alusrc    = idex_q.alusrc;
    assign idex_regW      = idex_q.regW;
    assign idex_memren    = idex_q.memren;
    assign idex_memwen    = idex_q.memwen;
    assign idex_ri_enable = idex_q.ri_enable;
    assign bubble_cnt     = bubble_cnt_q;

endmodule

// File: tb/tb_idex_stage.sv
// Scoreboard bench for idex_stage: driver pushes expected EX contents and hold flags,
// monitors pop and compare independently.
module tb_idex_stage;
    localparam int W = 32;
    localparam int R = 5;
    localparam int A = 4;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         en = 1'b0, flush = 1'b0, id_valid = 1'b0;
    logic [R-1:0] id_rs = '0, id_rt = '0, id_rd = '0;
    logic [W-1:0] id_rdat1 = '0, id_rdat2 = '0, id_imm32 = '0, id_pc4 = '0;
    logic [A-1:0] id_aluop = '0;
    logic         id_alusrc = 1'b0, id_regW = 1'b0, id_memren = 1'b0, id_memwen = 1'b0, id_ri_enable = 1'b0;

    logic         idex_valid, idex_alusrc, idex_regW, idex_memren, idex_memwen, idex_ri_enable, ifid_hold;
    logic [R-1:0] idex_rs, idex_rt, idex_rd;
    logic [W-1:0] idex_rdat1, idex_rdat2, idex_imm32, idex_pc4;
    logic [A-1:0] idex_aluop;
    logic [15:0]  bubble_cnt;

    idex_stage #(.WORD_W(W), .REG_W(R), .ALUOP_W(A)) dut (
        .CLK(CLK), .RST(RST), .en(en), .flush(flush), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rdat1(id_rdat1), .id_rdat2(id_rdat2), .id_imm32(id_imm32), .id_pc4(id_pc4),
        .id_aluop(id_aluop), .id_alusrc(id_alusrc), .id_regW(id_regW),
        .id_memren(id_memren), .id_memwen(id_memwen), .id_ri_enable(id_ri_enable),
        .idex_valid(idex_valid), .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_rd(idex_rd),
        .idex_rdat1(idex_rdat1), .idex_rdat2(idex_rdat2), .idex_imm32(idex_imm32),
        .idex_pc4(idex_pc4), .idex_aluop(idex_aluop), .idex_alusrc(idex_alusrc),
        .idex_regW(idex_regW), .idex_memren(idex_memren), .idex_memwen(idex_memwen),
        .idex_ri_enable(idex_ri_enable), .ifid_hold(ifid_hold), .bubble_cnt(bubble_cnt)
    );

    always #5 CLK = ~CLK;

    // What the EX stage holds, as the reference model sees it.
    typedef struct packed {
        logic         valid;
        logic [R-1:0] rs, rt, rd;
        logic [W-1:0] rdat1, rdat2, imm32, pc4;
        logic [A-1:0] aluop;
        logic         alusrc, regW, memren, memwen, ri;
    } ex_t;

    typedef struct packed {
        logic         rst, en, flush, valid;
        logic [R-1:0] rs, rt, rd;
        logic [W-1:0] rdat1, rdat2, imm32, pc4;
        logic [A-1:0] aluop;
        logic         alusrc, regW, memren, memwen, ri;
    } in_t;

    ex_t         ex_m = '0;
    int          cnt_m = 0;
    ex_t         ex_q[$];
    int          cnt_q[$];
    logic        hold_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic apply(input in_t s);
        logic reads_rd;
        logic hazard;
        @(negedge CLK);
        RST = s.rst; en = s.en; flush = s.flush; id_valid = s.valid;
        id_rs = s.rs; id_rt = s.rt; id_rd = s.rd;
        id_rdat1 = s.rdat1; id_rdat2 = s.rdat2; id_imm32 = s.imm32; id_pc4 = s.pc4;
        id_aluop = s.aluop; id_alusrc = s.alusrc; id_regW = s.regW;
        id_memren = s.memren; id_memwen = s.memwen; id_ri_enable = s.ri;
        // Does the decode instruction read the register the EX load is about to write?
        reads_rd = (s.rs == ex_m.rd) || ((s.rt == ex_m.rd) && (s.ri || s.memwen));
        hazard = ex_m.valid && ex_m.memren && ex_m.regW && (ex_m.rd != 0) && s.valid && reads_rd;
        hold_q.push_back(hazard && !s.flush && !s.rst);
        if (s.rst) begin
            ex_m = '0;
            cnt_m = 0;
        end else if (s.en && s.flush) begin
            ex_m = '0;
        end else if (s.en && hazard) begin
            ex_m = '0;
            cnt_m = (cnt_m >= 65535) ? 65535 : cnt_m + 1;
        end else if (s.en) begin
            ex_m.valid = s.valid;
            ex_m.rs = s.rs; ex_m.rt = s.rt; ex_m.rd = s.rd;
            ex_m.rdat1 = s.rdat1; ex_m.rdat2 = s.rdat2; ex_m.imm32 = s.imm32; ex_m.pc4 = s.pc4;
            ex_m.aluop  = s.valid ? s.aluop : '0;
            ex_m.alusrc = s.valid && s.alusrc;
            ex_m.regW   = s.valid && s.regW;
            ex_m.memren = s.valid && s.memren;
            ex_m.memwen = s.valid && s.memwen;
            ex_m.ri     = s.valid && s.ri;
        end
        ex_q.push_back(ex_m);
        cnt_q.push_back(cnt_m);
    endtask

    function automatic in_t base();
        in_t s = '0;
        s.en = 1'b1;
        s.valid = 1'b1;
        s.rdat1 = $urandom; s.rdat2 = $urandom; s.imm32 = $urandom; s.pc4 = $urandom;
        s.aluop = A'($urandom_range(0, 15));
        return s;
    endfunction

    function automatic in_t lw(input int rs, input int rd);
        in_t s = base();
        s.rs = R'(rs); s.rt = R'(rd); s.rd = R'(rd);
        s.alusrc = 1'b1; s.regW = 1'b1; s.memren = 1'b1;
        return s;
    endfunction

    function automatic in_t add(input int rs, input int rt, input int rd);
        in_t s = base();
        s.rs = R'(rs); s.rt = R'(rt); s.rd = R'(rd);
        s.regW = 1'b1; s.ri = 1'b1;
        return s;
    endfunction

    function automatic in_t sw(input int rs, input int rt);
        in_t s = base();
        s.rs = R'(rs); s.rt = R'(rt);
        s.alusrc = 1'b1; s.memwen = 1'b1;
        return s;
    endfunction

    function automatic in_t addi(input int rs, input int rt);
        in_t s = base();
        s.rs = R'(rs); s.rt = R'(rt); s.rd = R'(rt);
        s.alusrc = 1'b1; s.regW = 1'b1;
        return s;
    endfunction

    function automatic in_t rnd();
        in_t s = base();
        s.rst = ($urandom_range(0, 99) == 0);
        s.en = ($urandom_range(0, 9) != 0);
        s.flush = ($urandom_range(0, 9) == 0);
        s.valid = ($urandom_range(0, 7) != 0);
        s.rs = R'($urandom_range(0, 3)); s.rt = R'($urandom_range(0, 3)); s.rd = R'($urandom_range(0, 3));
        s.alusrc = 1'($urandom); s.regW = ($urandom_range(0, 3) != 0);
        s.memren = 1'($urandom); s.memwen = ($urandom_range(0, 3) == 0); s.ri = 1'($urandom);
        return s;
    endfunction

    // Monitor for the registered stage contents.
    initial begin
        forever begin
            ex_t  e, a;
            int   ec;
            @(posedge CLK);
            #1;
            if (ex_q.size() > 0) begin
                e = ex_q.pop_front();
                ec = cnt_q.pop_front();
                a = {idex_valid, idex_rs, idex_rt, idex_rd, idex_rdat1, idex_rdat2, idex_imm32,
                     idex_pc4, idex_aluop, idex_alusrc, idex_regW, idex_memren, idex_memwen, idex_ri_enable};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL idex_fields t=%0t: actual %h required %h", $time, a, e);
                end
                checks++;
                if (bubble_cnt !== 16'(ec)) begin
                    errors++;
                    $display("FAIL bubble_cnt t=%0t: actual %h required %h", $time, bubble_cnt, 16'(ec));
                end
            end
        end
    end

    // Monitor for the combinational hold, sampled mid-cycle after inputs settle.
    initial begin
        forever begin
            logic eh;
            @(negedge CLK);
            #2;
            if (hold_q.size() > 0) begin
                eh = hold_q.pop_front();
                checks++;
                if (ifid_hold !== eh) begin
                    errors++;
                    $display("FAIL ifid_hold t=%0t: actual %b required %b", $time, ifid_hold, eh);
                end
            end
        end
    end

    initial begin
        in_t s;
        s = '0; s.rst = 1'b1;
        apply(s); apply(s);

        // load-use on rs: one bubble, decode re-presented while held
        apply(lw(1, 8)); apply(add(8, 9, 10)); apply(add(8, 9, 10)); apply(add(0, 0, 0));
        // store data dependency on rt
        apply(lw(1, 8)); apply(sw(29, 8)); apply(sw(29, 8)); apply(add(0, 0, 0));
        // addi writes rt, so no dependency
        apply(lw(1, 8)); apply(addi(9, 8)); apply(add(0, 0, 0));
        // $0 destination never hazards
        apply(lw(1, 0)); apply(add(0, 0, 1)); apply(add(0, 0, 0));
        // flush beats hazard
        apply(lw(1, 8)); s = add(8, 9, 10); s.flush = 1'b1; apply(s); apply(add(0, 0, 0));
        // memory stall freezes everything, including a pending hazard
        apply(lw(1, 8));
        for (int i = 0; i < 3; i++) begin
            s = rnd(); s.rst = 1'b0; s.en = 1'b0; apply(s);
        end
        apply(add(8, 9, 10)); apply(add(8, 9, 10));
        // chained loads
        apply(lw(1, 8)); apply(lw(8, 9)); apply(lw(8, 9)); apply(add(9, 9, 2)); apply(add(9, 9, 2));

        // saturation: preload the counter close to its limit
        @(posedge CLK);
        #2;
        dut.bubble_cnt_q <= 16'hFFFE;
        cnt_m = 65534;
        apply(lw(1, 8)); apply(add(8, 0, 3)); apply(add(8, 0, 3));
        apply(lw(1, 8)); apply(add(8, 0, 3)); apply(add(8, 0, 3));
        @(posedge CLK);
        #1;
        checks++;
        if (bubble_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL bubble_cnt_saturated: actual %h required ffff", bubble_cnt);
        end
        // reset mid-hazard
        apply(lw(1, 8)); s = add(8, 9, 10); s.rst = 1'b1; apply(s); apply(add(0, 0, 0));

        for (int i = 0; i < 3000; i++) apply(rnd());

        repeat (3) @(posedge CLK);
        #3;
        checks++;
        if (ex_q.size() != 0 || hold_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: actual %0d/%0d pending required 0/0", ex_q.size(), hold_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
